// File: rtl/m_dmem_resp.sv
// m_dmem_resp: single-outstanding data-memory responder.
// One request is captured, a fixed LATENCY later the memory is accessed and a
// response is held until the initiator takes it. Only then may a new request
// be accepted.
//
// Handshake rules: a transfer happens on a rising w_clk edge where valid and
// ready are both 1 on the same channel. The request fields are sampled only on
// that edge. The response fields stay stable while w_rsp_valid=1 and
// w_rsp_ready=0.
module m_dmem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_req_valid,
    output logic        w_req_ready,
    input  logic        w_req_we,
    input  logic [31:0] w_req_addr,
    input  logic [31:0] w_req_wdata,
    output logic        w_rsp_valid,
    input  logic        w_rsp_ready,
    output logic [31:0] w_rsp_rdata,
    output logic        w_rsp_err
);

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("m_dmem_resp: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // state is the FSM observation point for checkers.
    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;

    logic        req_we_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    // Storage starts at zero. Reset never touches it.
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    logic          accept;
    logic          finish;
    logic          req_err;
    logic [AW-1:0] word_idx;

    assign w_req_ready = (state == IDLE) && !w_rst;
    assign w_rsp_valid = (state == RESP);
    assign w_rsp_rdata = rsp_rdata_q;
    assign w_rsp_err   = rsp_err_q;

    assign accept   = w_req_valid && w_req_ready;
    assign finish   = (state == BUSY) && (cnt == 4'd0);
    assign word_idx = req_addr_q[AW+1:2];
    assign req_err  = (req_addr_q[1:0] != 2'b00) ||
                      ({2'b00, req_addr_q[31:2]} >= 32'(DEPTH_WORDS));

    // State register; reset drops any pending request or response.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept -> wait out the latency -> hold until taken.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (w_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, latency countdown and response registers.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            cnt         <= 4'd0;
            req_we_q    <= 1'b0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                cnt         <= CNT_INIT;
                req_we_q    <= w_req_we;
                req_addr_q  <= w_req_addr;
                req_wdata_q <= w_req_wdata;
            end else if ((state == BUSY) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            if (finish) begin
                rsp_err_q   <= req_err;
                rsp_rdata_q <= (!req_we_q && !req_err) ? mem[word_idx] : 32'd0;
            end else if ((state == RESP) && w_rsp_ready) begin
                // Clear on hand-off so err reads 0 outside RESP.
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= 32'd0;
            end
        end
    end

    // Memory write happens on the same edge that raises the response.
    always_ff @(posedge w_clk) begin
        if (finish && req_we_q && !req_err && !w_rst) begin
            mem[word_idx] <= req_wdata_q;
        end
    end

endmodule

// File: tb/tb_m_dmem_resp.sv
// Testbench for m_dmem_resp. Three instances (LATENCY 1, 2, 15) share the
// clock, reset and request fields. Each instance has its own request valid.
// The reference is a word-addressed associative memory per instance.
module tb_m_dmem_resp;

  localparam int DEPTH = 1024;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic [2:0]  req_valid_v = 3'b000;
  logic        w_req_we = 1'b0;
  logic [31:0] w_req_addr = 32'd0;
  logic [31:0] w_req_wdata = 32'd0;
  logic        w_rsp_ready = 1'b1;
  logic [2:0]  req_ready_v;
  logic [2:0]  rsp_valid_v;
  logic [2:0]  rsp_err_v;
  logic [31:0] rsp_rdata_a [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [int];

  always #5 w_clk = ~w_clk;

  m_dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_lat1 (
    .w_clk(w_clk), .w_rst(w_rst), .w_req_valid(req_valid_v[0]), .w_req_ready(req_ready_v[0]),
    .w_req_we(w_req_we), .w_req_addr(w_req_addr), .w_req_wdata(w_req_wdata),
    .w_rsp_valid(rsp_valid_v[0]), .w_rsp_ready(w_rsp_ready), .w_rsp_rdata(rsp_rdata_a[0]),
    .w_rsp_err(rsp_err_v[0]));

  m_dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_lat2 (
    .w_clk(w_clk), .w_rst(w_rst), .w_req_valid(req_valid_v[1]), .w_req_ready(req_ready_v[1]),
    .w_req_we(w_req_we), .w_req_addr(w_req_addr), .w_req_wdata(w_req_wdata),
    .w_rsp_valid(rsp_valid_v[1]), .w_rsp_ready(w_rsp_ready), .w_rsp_rdata(rsp_rdata_a[1]),
    .w_rsp_err(rsp_err_v[1]));

  m_dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(15)) u_lat15 (
    .w_clk(w_clk), .w_rst(w_rst), .w_req_valid(req_valid_v[2]), .w_req_ready(req_ready_v[2]),
    .w_req_we(w_req_we), .w_req_addr(w_req_addr), .w_req_wdata(w_req_wdata),
    .w_rsp_valid(rsp_valid_v[2]), .w_rsp_ready(w_rsp_ready), .w_rsp_rdata(rsp_rdata_a[2]),
    .w_rsp_err(rsp_err_v[2]));

  function automatic int lat_of(input int sel);
    case (sel)
      0:       return 1;
      1:       return 2;
      default: return 15;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Complete one transaction on instance sel and compare with the model.
  // hold = number of cycles the response is back-pressured.
  task automatic do_txn(input int sel, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
    int          waited;
    int          first;
    int          key;
    bit          exp_err;
    logic [31:0] exp_rd;
    waited = 0;
    @(negedge w_clk);
    while (!req_ready_v[sel] && waited < 50) begin
      @(negedge w_clk);
      waited++;
    end
    check_eq("req_ready_before_accept", 32'(req_ready_v[sel]), 32'd1);
    req_valid_v[sel] = 1'b1;
    w_req_we    = we;
    w_req_addr  = addr;
    w_req_wdata = wdata;
    w_rsp_ready = (hold == 0);
    @(posedge w_clk);
    exp_err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH));
    key     = sel * 65536 + int'(addr >> 2);
    exp_rd  = 32'd0;
    if (!exp_err && !we && model_mem.exists(key)) exp_rd = model_mem[key];
    if (!exp_err && we) model_mem[key] = wdata;
    @(negedge w_clk);
    req_valid_v[sel] = 1'b0;
    w_req_we    = 1'($urandom);
    w_req_addr  = $urandom;
    w_req_wdata = $urandom;
    check_eq("busy_rsp_valid", 32'(rsp_valid_v[sel]), 32'd0);
    check_eq("busy_rsp_err", 32'(rsp_err_v[sel]), 32'd0);
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge w_clk);
      #1;
      if (rsp_valid_v[sel]) begin
        first = k;
        break;
      end
    end
    check_eq("rsp_latency", 32'(first), 32'(lat_of(sel)));
    if (first == 0) return;
    check_eq("rsp_rdata", rsp_rdata_a[sel], exp_rd);
    check_eq("rsp_err", 32'(rsp_err_v[sel]), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(posedge w_clk);
      #1;
      check_eq("bp_rsp_valid", 32'(rsp_valid_v[sel]), 32'd1);
      check_eq("bp_rsp_rdata", rsp_rdata_a[sel], exp_rd);
      check_eq("bp_rsp_err", 32'(rsp_err_v[sel]), 32'(exp_err));
      check_eq("bp_req_ready", 32'(req_ready_v[sel]), 32'd0);
    end
    if (hold != 0) begin
      @(negedge w_clk);
      w_rsp_ready = 1'b1;
    end
    @(posedge w_clk);
    #1;
    check_eq("post_hs_rsp_valid", 32'(rsp_valid_v[sel]), 32'd0);
    check_eq("post_hs_req_ready", 32'(req_ready_v[sel]), 32'd1);
    check_eq("post_hs_rsp_err", 32'(rsp_err_v[sel]), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1:    return 32'($urandom_range(0, 15)) * 32'd4;
      2:       return 32'($urandom_range(0, 63));
      3:       return $urandom;
      4:       return 32'(4 * (DEPTH - 1));
      default: return 32'(4 * DEPTH);
    endcase
  endfunction

  initial begin : main
    int waited;
    // Outputs under reset, before any clock edge.
    #1;
    for (int s = 0; s < 3; s++) begin
      check_eq("rst_req_ready", 32'(req_ready_v[s]), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid_v[s]), 32'd0);
      check_eq("rst_rsp_rdata", rsp_rdata_a[s], 32'd0);
      check_eq("rst_rsp_err", 32'(rsp_err_v[s]), 32'd0);
    end
    repeat (2) @(posedge w_clk);
    @(negedge w_clk);
    w_rst = 1'b0;
    #1;
    check_eq("rst_release_ready", 32'(req_ready_v[1]), 32'd1);

    // Store/load on LATENCY=2, then back-pressure, then error cases.
    do_txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    do_txn(1, 1'b0, 32'h10, 32'h0, 0);
    do_txn(1, 1'b0, 32'h10, 32'h0, 5);
    do_txn(1, 1'b1, 32'h12, 32'h1, 0);
    do_txn(1, 1'b0, 32'h10, 32'h0, 0);
    check_eq("model_after_err_store", model_mem[65536 + 4], 32'hDEADBEEF);
    do_txn(1, 1'b0, 32'h1000, 32'h0, 1);

    // Reset during BUSY: the pending store must not land.
    @(negedge w_clk);
    req_valid_v[1] = 1'b1;
    w_req_we = 1'b1;
    w_req_addr = 32'h20;
    w_req_wdata = 32'h55;
    @(posedge w_clk);
    #1;
    req_valid_v[1] = 1'b0;
    w_rst = 1'b1;
    #1;
    check_eq("busy_rst_req_ready", 32'(req_ready_v[1]), 32'd0);
    check_eq("busy_rst_rsp_valid", 32'(rsp_valid_v[1]), 32'd0);
    check_eq("busy_rst_rsp_rdata", rsp_rdata_a[1], 32'd0);
    check_eq("busy_rst_rsp_err", 32'(rsp_err_v[1]), 32'd0);
    repeat (3) begin
      @(posedge w_clk);
      #1;
      check_eq("busy_rst_hold_valid", 32'(rsp_valid_v[1]), 32'd0);
    end
    @(negedge w_clk);
    w_rst = 1'b0;
    #1;
    check_eq("busy_rst_release_ready", 32'(req_ready_v[1]), 32'd1);
    do_txn(1, 1'b0, 32'h20, 32'h0, 0);
    do_txn(1, 1'b0, 32'h10, 32'h0, 0);

    // Reset during RESP: the response is dropped without a handshake.
    @(negedge w_clk);
    req_valid_v[1] = 1'b1;
    w_req_we = 1'b0;
    w_req_addr = 32'h10;
    w_rsp_ready = 1'b0;
    @(posedge w_clk);
    @(negedge w_clk);
    req_valid_v[1] = 1'b0;
    waited = 0;
    while (!rsp_valid_v[1] && waited < 20) begin
      @(negedge w_clk);
      waited++;
    end
    check_eq("resp_rst_reached_resp", 32'(rsp_valid_v[1]), 32'd1);
    w_rst = 1'b1;
    #1;
    check_eq("resp_rst_rsp_valid", 32'(rsp_valid_v[1]), 32'd0);
    check_eq("resp_rst_rsp_rdata", rsp_rdata_a[1], 32'd0);
    @(negedge w_clk);
    w_rst = 1'b0;
    w_rsp_ready = 1'b1;
    #1;
    check_eq("resp_rst_release_ready", 32'(req_ready_v[1]), 32'd1);
    do_txn(1, 1'b0, 32'h10, 32'h0, 0);

    // Latency extremes.
    do_txn(0, 1'b1, 32'h40, 32'hA5A5_0001, 0);
    do_txn(0, 1'b0, 32'h40, 32'h0, 2);
    do_txn(2, 1'b1, 32'h40, 32'h5A5A_0002, 0);
    do_txn(2, 1'b0, 32'h40, 32'h0, 2);
    do_txn(2, 1'b0, 32'(4 * DEPTH - 4), 32'h0, 0);

    // Randomized traffic on every instance.
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 30; n++) begin
        do_txn(s, 1'($urandom), rand_addr(), $urandom, int'($urandom_range(0, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/m_dmem_resp.md
M_DMEM_RESP -- requirements
Module: m_dmem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit storage words.
REQ-002 The block SHALL have parameter LATENCY, default 2: cycles from request acceptance to response valid; legal range 1..15.
REQ-003 The block SHALL have one clock and one reset: w_clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 w_rst  input  1  reset, asynchronous, active-high.
REQ-005 w_req_valid  input  1  initiator presents a request.
REQ-006 w_req_ready  output  1  block can accept a request this cycle.
REQ-007 w_req_we  input  1  1 = store, 0 = load.
REQ-008 w_req_addr  input  32  byte address.
REQ-009 w_req_wdata  input  32  store data.
REQ-010 w_rsp_valid  output  1  response available.
REQ-011 w_rsp_ready  input  1  initiator accepts the response.
REQ-012 w_rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 w_rsp_err  output  1  request was misaligned or out of range.

Function
REQ-014 The block SHALL be a single-outstanding data-memory responder with FSM states IDLE, BUSY, RESP.
REQ-015 w_req_ready SHALL be 1 exactly when state is IDLE and w_rst is 0.
REQ-016 A request SHALL be accepted on a rising edge with w_req_valid=1 and w_req_ready=1; we, addr and wdata are captured then and later input changes are ignored.
REQ-017 On acceptance the FSM SHALL go IDLE->BUSY and load a down-counter with LATENCY-1.
REQ-018 In BUSY the counter SHALL decrement each edge; at the edge where it equals 0 the FSM SHALL go BUSY->RESP, so w_rsp_valid rises exactly LATENCY edges after the accepting edge.
REQ-019 The request SHALL be in error when captured addr[1:0] != 0 or captured addr[31:2] >= DEPTH_WORDS.
REQ-020 On the BUSY->RESP edge a non-error store SHALL write wdata to word addr[31:2]; an error store SHALL NOT modify memory.
REQ-021 On the BUSY->RESP edge a non-error load SHALL register the word at addr[31:2] into w_rsp_rdata.
REQ-022 On the BUSY->RESP edge, stores and error requests SHALL set w_rsp_rdata to 0; w_rsp_err is set to the error flag.
REQ-023 In RESP w_rsp_valid SHALL be 1, and w_rsp_rdata and w_rsp_err SHALL hold stable until a rising edge with w_rsp_ready=1, at which the FSM goes RESP->IDLE.
REQ-024 In IDLE and BUSY w_rsp_valid SHALL be 0 and w_rsp_err SHALL be 0.
REQ-025 No overlap: the next request SHALL NOT be accepted on the edge that completes the response; w_req_ready rises in the cycle after that edge.
REQ-026 A load issued after a completed store to the same word SHALL return the stored value.
REQ-027 Memory contents SHALL be initialised to all zero at time 0.

Reset
REQ-028 While w_rst=1 the state SHALL be IDLE, the counter 0, w_req_ready 0, w_rsp_valid 0, w_rsp_rdata 0 and w_rsp_err 0, independent of w_clk.
REQ-029 Reset asserted in BUSY SHALL discard the pending request; a pending store is not written.
REQ-030 Reset asserted in RESP SHALL drop the response without handshake.
REQ-031 Reset SHALL NOT alter memory contents.
REQ-032 After w_rst falls, w_req_ready SHALL be 1 in the same cycle.

Verification
REQ-033 Store then load, LATENCY=2: store addr 0x10 data 0xDEADBEEF, then load 0x10 -> each w_rsp_valid rises 2 edges after acceptance; load rdata=0xDEADBEEF with err=0; store rdata=0.
REQ-034 Response backpressure: hold w_rsp_ready=0 for 5 cycles after a load from 0x10 -> w_rsp_valid=1 and rdata=0xDEADBEEF stable throughout; w_req_ready=0 throughout; w_req_ready=1 in the cycle after the handshake.
REQ-035 Errors: store to 0x12 data 0x1 -> err=1 and a later load of 0x10 still returns 0xDEADBEEF; load from 4*DEPTH_WORDS (0x1000) -> err=1, rdata=0.
REQ-036 Reset mid-operation: accept a store to 0x20 data 0x55, assert w_rst during BUSY, release, then load 0x20 -> rdata=0 and w_rsp_valid was 0 during reset.
REQ-037 Latency sweep: run LATENCY=1 and LATENCY=15 -> w_rsp_valid rises exactly 1 and 15 edges after acceptance; input changes after acceptance do not affect the response.
